sort8_stream: RTL and testbench
===============================

SORT8_STREAM -- requirements
Module: sort8_stream

Interface
REQ-001 Parameter Width, default 16, bits per number.
REQ-002 Parameter SyncStages, default 2, flops in the fin synchronizer (min 2).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream word valid.
REQ-006 in_ready  output  1  block accepts a word this cycle.
REQ-007 in_data  input  Width  unsorted word.
REQ-008 req  output  1  request to the sort8 network (four-phase).
REQ-009 numberInput  output  Width*8  packed operand line to sort8; lane k at bits k*Width+:Width.
REQ-010 fin  input  1  sort8 completion, asynchronous to clk.
REQ-011 numberOutput  input  Width*8  sorted line from sort8, lane 0 smallest.
REQ-012 out_valid  output  1  sorted word valid.
REQ-013 out_ready  input  1  downstream accepts word.
REQ-014 out_data  output  Width  sorted word.
REQ-015 out_last  output  1  high with the 8th (largest) word.
REQ-016 busy  output  1  high in any state other than FILL.

Function
REQ-017 FSM states: FILL, WAIT0, REQ, RTZ, DRAIN.
REQ-018 FILL: in_ready=1; on in_valid&in_ready, in_data written to lane cnt, cnt (3-bit) increments; on 8th accept (cnt==7), cnt wraps to 0 and next state WAIT0.
REQ-019 WAIT0: req=0; proceed to REQ when synchronized fin==0.
REQ-020 REQ: req=1 registered; numberInput held constant; on synchronized fin==1, numberOutput captured into the 8-lane result register, next state RTZ.
REQ-021 RTZ: req=0; proceed to DRAIN when synchronized fin==0; numberInput held.
REQ-022 DRAIN: out_valid=1, out_data=result lane cnt, out_last=(cnt==7); cnt advances only on out_valid&out_ready; after lane 7 accepted, cnt=0, next state FILL.
REQ-023 in_ready=0 in every state except FILL; out_valid=0 in every state except DRAIN.
REQ-024 req, out_valid, out_data, out_last, in_ready driven from registers/state decode only; no combinational path from in_valid or out_ready to req.
REQ-025 numberInput changes only in FILL, never while req=1 or in RTZ.
REQ-026 fin passes through exactly SyncStages flops before use; raw fin never used.
REQ-027 Latency: first out_valid no earlier than SyncStages*2+3 cycles after the 8th input accept.
REQ-028 Backpressure: out_data/out_last stable while out_valid=1 and out_ready=0.
REQ-029 Duplicate values sorted stably by network; block passes values unmodified.

Reset
REQ-030 On rst_n=0: state=FILL, cnt=0, req=0, in_ready=1 after release, out_valid=0, out_last=0, out_data=0, numberInput=0, result=0, synchronizer flops=0.
REQ-031 Reset mid-operation discards partial fill and pending results; first post-reset req waits in WAIT0 for synchronized fin==0.

Structure
REQ-032 Package sort8_pkg holds the state enum, lane count constant (8), and default Width.
REQ-033 One sub-module: sync_bit (SyncStages-deep synchronizer, async active-low reset).

Verification
REQ-034 Stream 7,3,5,1,8,2,6,4 with out_ready=1 -> out_data 1..8 in order, out_last only with 8, req pulses once.
REQ-035 Inputs 0xFFFF,0,0xFFFF,0,... -> four 0x0000 then four 0xFFFF; no width truncation.
REQ-036 out_ready toggled 1-in-3 -> out_data held stable while stalled; all 8 words delivered once.
REQ-037 fin held high 20 cycles after req drop -> block stays in RTZ, out_valid=0 until fin low +SyncStages.
REQ-038 rst_n asserted after 5 inputs and again during REQ -> req=0 immediately, next 8 inputs sorted correctly.
REQ-039 Back-to-back batches 8,7,..,1 then 10,10,9,... -> two sorted batches, in_ready=0 throughout DRAIN.

Source files
------------

// File: rtl/sort8_pkg.sv
// Shared types and constants for the sort8 streaming wrapper.
package sort8_pkg;

   localparam int unsigned LANES         = 8;
   localparam int unsigned CNT_W         = 3;
   localparam int unsigned DEFAULT_WIDTH = 16;

   // Controller states:
   //   ST_FILL  | collecting eight words into the operand line
   //   ST_WAIT0 | operand line full, waiting for the network to be idle (fin low)
   //   ST_REQ   | req raised, waiting for fin high, then capture the sorted line
   //   ST_RTZ   | req dropped, waiting for fin to return low
   //   ST_DRAIN | streaming the eight sorted words out, smallest first
   typedef enum logic [2:0] {
      ST_FILL  = 3'd0,
      ST_WAIT0 = 3'd1,
      ST_REQ   = 3'd2,
      ST_RTZ   = 3'd3,
      ST_DRAIN = 3'd4
   } state_e;

endpackage

// File: rtl/sort8_stream_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level.
module sync_bit #(
   parameter int unsigned Stages = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   // Fewer than two flops would not give metastability time to settle.
   localparam int unsigned S = (Stages < 2) ? 2 : Stages;

   logic [S-1:0] sync_q;

   // Shift the raw level through the flop chain; the last flop is the only one used.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[S-2:0], d_i};
      end
   end

   assign q_o = sync_q[S-1];

endmodule

// File: rtl/sort8_stream.sv
// Streaming wrapper around an asynchronous four-phase sort8 network:
// gathers eight words, hands them to the network, streams the sorted result.
module sort8_stream
   import sort8_pkg::*;
#(
   parameter int unsigned Width      = DEFAULT_WIDTH,
   parameter int unsigned SyncStages = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [Width-1:0]       in_data,
   output logic                   req,
   output logic [Width*8-1:0]     numberInput,
   input  logic                   fin,
   input  logic [Width*8-1:0]     numberOutput,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [Width-1:0]       out_data,
   output logic                   out_last,
   output logic                   busy
);

   localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

   state_e                         state_q, state_d;
   logic [CNT_W-1:0]               cnt_q, cnt_d;
   logic [LANES-1:0][Width-1:0]    lanes_q, lanes_d;
   logic [LANES-1:0][Width-1:0]    result_q, result_d;
   logic                           req_q, req_d;
   logic                           fin_s;

   sync_bit #(
      .Stages (SyncStages)
   ) u_fin_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (fin),
      .q_o   (fin_s)
   );

   // State, counter, operand line, result line and req flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_FILL;
         cnt_q    <= '0;
         lanes_q  <= '0;
         result_q <= '0;
         req_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         lanes_q  <= lanes_d;
         result_q <= result_d;
         req_q    <= req_d;
      end
   end

   // Next-state logic; the operand line is only written in ST_FILL so it is
   // frozen for the whole handshake, and the result only loads on fin rising.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      lanes_d  = lanes_q;
      result_d = result_q;

      unique case (state_q)
         ST_FILL: begin
            if (in_valid) begin
               lanes_d[cnt_q] = in_data;
               cnt_d          = cnt_q + 1'b1;
               if (cnt_q == LAST_LANE) begin
                  state_d = ST_WAIT0;
               end
            end
         end
         ST_WAIT0: begin
            if (!fin_s) begin
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (fin_s) begin
               result_d = numberOutput;
               state_d  = ST_RTZ;
            end
         end
         ST_RTZ: begin
            if (!fin_s) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (out_ready) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST_LANE) begin
                  state_d = ST_FILL;
               end
            end
         end
         default: begin
            state_d = ST_FILL;
            cnt_d   = '0;
         end
      endcase

      // req comes from its own flop so the network never sees a decode glitch.
      req_d = (state_d == ST_REQ);
   end

   assign req         = req_q;
   assign numberInput = lanes_q;
   assign in_ready    = (state_q == ST_FILL);
   assign busy        = (state_q != ST_FILL);
   assign out_valid   = (state_q == ST_DRAIN);
   assign out_data    = result_q[cnt_q];
   assign out_last    = (state_q == ST_DRAIN) && (cnt_q == LAST_LANE);

endmodule

// File: tb/tb_sort8_stream.sv
// Directed bench for sort8_stream with a behavioural asynchronous sort8 network.
module tb_sort8_stream;

   localparam int W    = 16;
   localparam int SYNC = 2;
   localparam int MIN_LAT = SYNC * 2 + 3;

   typedef struct packed {
      logic [7:0][W-1:0] din;
      logic [7:0][W-1:0] dexp;
      logic              stall;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     in_data;
   logic             req;
   logic [W*8-1:0]   numberInput;
   logic             fin;
   logic [W*8-1:0]   numberOutput;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     out_data;
   logic             out_last;
   logic             busy;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int accept_cyc = 0;
   int fin_fall_cyc = 0;
   int req_pulses = 0;
   logic hold_fin = 1'b0;

   vec_t vecs [5];

   sort8_stream #(.Width(W), .SyncStages(SYNC)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .req          (req),
      .numberInput  (numberInput),
      .fin          (fin),
      .numberOutput (numberOutput),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_last     (out_last),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge req) req_pulses++;

   function automatic logic [7:0][W-1:0] pack8(input logic [W-1:0] a0, a1, a2, a3,
                                                a4, a5, a6, a7);
      logic [7:0][W-1:0] r;
      r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
      r[4] = a4; r[5] = a5; r[6] = a6; r[7] = a7;
      return r;
   endfunction

   function automatic logic [W*8-1:0] net_sort(input logic [W*8-1:0] x);
      logic [7:0][W-1:0] a;
      logic [W-1:0]      t;
      a = x;
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 7 - i; j++) begin
            if (a[j] > a[j+1]) begin
               t = a[j]; a[j] = a[j+1]; a[j+1] = t;
            end
         end
      end
      return a;
   endfunction

   // Behavioural sort8 network: four-phase, responds a few ns after req edges.
   initial begin
      fin = 1'b0;
      numberOutput = '0;
      forever begin
         wait (req === 1'b1);
         #3;
         numberOutput = net_sort(numberInput);
         fin = 1'b1;
         wait (req === 1'b0);
         if (hold_fin) repeat (20) @(posedge clk);
         #3;
         fin = 1'b0;
         fin_fall_cyc = cyc;
      end
   end

   task automatic chk(input string name, input logic [W*8-1:0] act, input logic [W*8-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic send_batch(input logic [7:0][W-1:0] d, input int n);
      int guard;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = d[i];
         guard = 0;
         while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
         end
         if (guard >= 200) chk("in_ready_timeout", 1'b0, 1'b1);
         @(posedge clk);
         #1;
      end
      accept_cyc = cyc;
      in_valid = 1'b0;
   endtask

   task automatic drain_check(input logic [7:0][W-1:0] exp, input logic stall,
                              input logic [7:0][W-1:0] din, output int first_cyc);
      int idx, guard, sc;
      logic held_valid, held_last, rdy;
      logic [W-1:0] held_data;
      idx = 0; guard = 0; sc = 0;
      held_valid = 1'b0; held_last = 1'b0; held_data = '0;
      first_cyc = -1;
      while (idx < 8 && guard < 1000) begin
         @(negedge clk);
         guard++;
         out_ready = 1'b0;
         if (out_valid) begin
            if (first_cyc < 0) begin
               first_cyc = cyc;
               chk("number_input_held", numberInput, din);
            end
            if (held_valid) begin
               chk("stall_data_stable", out_data, held_data);
               chk("stall_last_stable", out_last, held_last);
            end else begin
               chk("out_data", out_data, exp[idx]);
               chk("out_last", out_last, (idx == 7));
            end
            chk("in_ready_in_drain", in_ready, 1'b0);
            rdy = stall ? (sc % 3 == 2) : 1'b1;
            sc++;
            out_ready = rdy;
            if (rdy) begin
               idx++;
               held_valid = 1'b0;
            end else begin
               held_valid = 1'b1;
               held_data  = out_data;
               held_last  = out_last;
            end
         end
      end
      if (idx < 8) chk("drain_timeout", idx, 8);
      @(negedge clk);
      out_ready = 1'b0;
      chk("back_to_fill_in_ready", in_ready, 1'b1);
      chk("back_to_fill_out_valid", out_valid, 1'b0);
   endtask

   task automatic run_batch(input vec_t v, output int first_cyc);
      int p0;
      p0 = req_pulses;
      send_batch(v.din, 8);
      drain_check(v.dexp, v.stall, v.din, first_cyc);
      chk("latency_min", (first_cyc - accept_cyc) >= MIN_LAT, 1'b1);
      chk("req_pulse_count", req_pulses - p0, 1);
   endtask

   initial begin
      int first;
      int guard;
      logic [7:0][W-1:0] d;

      vecs[0].din  = pack8(7, 3, 5, 1, 8, 2, 6, 4);
      vecs[0].dexp = pack8(1, 2, 3, 4, 5, 6, 7, 8);
      vecs[0].stall = 1'b0;
      vecs[1].din  = pack8(16'hFFFF, 0, 16'hFFFF, 0, 16'hFFFF, 0, 16'hFFFF, 0);
      vecs[1].dexp = pack8(0, 0, 0, 0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
      vecs[1].stall = 1'b0;
      vecs[2].din  = pack8(8, 7, 6, 5, 4, 3, 2, 1);
      vecs[2].dexp = pack8(1, 2, 3, 4, 5, 6, 7, 8);
      vecs[2].stall = 1'b0;
      vecs[3].din  = pack8(10, 10, 9, 9, 8, 8, 7, 7);
      vecs[3].dexp = pack8(7, 7, 8, 8, 9, 9, 10, 10);
      vecs[3].stall = 1'b0;
      vecs[4].din  = pack8(16'h1234, 16'h0001, 16'hABCD, 16'h8000,
                           16'h7FFF, 16'h0010, 16'hFFFE, 16'h0100);
      vecs[4].dexp = pack8(16'h0001, 16'h0010, 16'h0100, 16'h1234,
                           16'h7FFF, 16'h8000, 16'hABCD, 16'hFFFE);
      vecs[4].stall = 1'b1;

      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_req", req, 1'b0);
      chk("rst_out_last", out_last, 1'b0);
      chk("rst_out_data", out_data, '0);
      chk("rst_number_input", numberInput, '0);
      chk("rst_busy", busy, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", in_ready, 1'b1);

      // Table: plain, width extremes, back-to-back pair, 1-in-3 backpressure.
      for (int i = 0; i < 5; i++) begin
         run_batch(vecs[i], first);
      end

      // fin held high after req drops: drain must wait for fin low + sync.
      hold_fin = 1'b1;
      d = pack8(100, 50, 75, 25, 0, 200, 150, 125);
      send_batch(d, 8);
      drain_check(pack8(0, 25, 50, 75, 100, 125, 150, 200), 1'b0, d, first);
      chk("fin_hold_wait", first >= fin_fall_cyc + SYNC + 1, 1'b1);
      chk("fin_hold_long", (first - accept_cyc) >= 20, 1'b1);
      hold_fin = 1'b0;

      // Reset after five inputs: partial fill discarded.
      send_batch(pack8(50, 40, 30, 20, 10, 0, 0, 0), 5);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midfill_rst_busy", busy, 1'b0);
      chk("midfill_rst_number_input", numberInput, '0);
      @(negedge clk);
      rst_n = 1'b1;
      vecs[0].din  = pack8(9, 1, 8, 2, 7, 3, 6, 4);
      vecs[0].dexp = pack8(1, 2, 3, 4, 6, 7, 8, 9);
      run_batch(vecs[0], first);

      // Reset while req is high: req drops at once, pending result discarded.
      send_batch(pack8(5, 6, 7, 8, 1, 2, 3, 4), 8);
      guard = 0;
      while (req !== 1'b1 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      chk("req_seen_before_rst", req, 1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("req_drop_on_reset", req, 1'b0);
      chk("rst_in_req_out_valid", out_valid, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_req_rst_in_ready", in_ready, 1'b1);
      chk("post_req_rst_out_valid", out_valid, 1'b0);
      vecs[1].din  = pack8(3, 3, 1, 2, 2, 1, 0, 3);
      vecs[1].dexp = pack8(0, 1, 1, 2, 2, 3, 3, 3);
      vecs[1].stall = 1'b1;
      run_batch(vecs[1], first);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
